vending_fsm_param: RTL and testbench

//  Parametrised vending controller; successor to the fixed-price 20c soda FSM.

---
 rtl/vending_fsm_param.sv | 182 ++++++++++++++++++
 tb/tb_vending_fsm_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: collects nickel/dime/quarter credit up to PRICE,
// pulses o_soda, then pays change or a cancel refund coin-by-coin through a ready/ack hopper.
module vending_fsm_param #(
  parameter int PRICE       = 20,
  parameter int CREDIT_W    = 8,
  parameter bit DIME_CHANGE = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_nickel,
  input  logic                i_dime,
  input  logic                i_quarter,
  input  logic                i_cancel,
  input  logic                i_change_ack,
  output logic                o_soda,
  output logic                o_coin_reject,
  output logic                o_change_valid,
  output logic [1:0]          o_change_coin,
  output logic                o_refunding,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    VEND     = 2'd2,
    DISPENSE = 2'd3
  } state_t;

  localparam logic [1:0]          COIN_NONE   = 2'b00;
  localparam logic [1:0]          COIN_NICKEL = 2'b01;
  localparam logic [1:0]          COIN_DIME   = 2'b10;
  localparam logic [CREDIT_W-1:0] VAL_NICKEL  = CREDIT_W'(32'd5);
  localparam logic [CREDIT_W-1:0] VAL_DIME    = CREDIT_W'(32'd10);
  localparam logic [CREDIT_W-1:0] VAL_QUARTER = CREDIT_W'(32'd25);
  localparam logic [CREDIT_W-1:0] PRICE_C     = CREDIT_W'(PRICE);

  // Greedy change: largest allowed coin that does not exceed the amount owed.
  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] owed);
    if (DIME_CHANGE && (owed >= VAL_DIME)) begin
      pick_coin = COIN_DIME;
    end else begin
      pick_coin = COIN_NICKEL;
    end
  endfunction

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_DIME:   coin_value = VAL_DIME;
      COIN_NICKEL: coin_value = VAL_NICKEL;
      default:     coin_value = '0;
    endcase
  endfunction

  state_t              r_state;
  logic                r_soda;
  logic                r_reject;
  logic                r_change_valid;
  logic [1:0]          r_change_coin;
  logic                r_refund;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_busy;

  logic [1:0]          w_coin_cnt;
  logic                w_any_coin;
  logic                w_accept;
  logic                w_reject;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W-1:0] w_sum;
  logic [CREDIT_W-1:0] w_after_vend;
  logic [CREDIT_W-1:0] w_after_pay;

  // Coin decode and the candidate credit values for each transition.
  always_comb begin
    w_coin_cnt = {1'b0, i_nickel} + {1'b0, i_dime} + {1'b0, i_quarter};
    w_any_coin = i_nickel | i_dime | i_quarter;
    w_accept   = (w_coin_cnt == 2'd1) && !i_cancel;
    if ((r_state == VEND) || (r_state == DISPENSE)) begin
      w_reject = w_any_coin;
    end else begin
      w_reject = w_any_coin && ((w_coin_cnt > 2'd1) || i_cancel);
    end
    if (i_quarter) begin
      w_coin_val = VAL_QUARTER;
    end else if (i_dime) begin
      w_coin_val = VAL_DIME;
    end else if (i_nickel) begin
      w_coin_val = VAL_NICKEL;
    end else begin
      w_coin_val = '0;
    end
    w_sum        = r_credit + w_coin_val;
    w_after_vend = r_credit - PRICE_C;
    w_after_pay  = r_credit - coin_value(r_change_coin);
  end

  // Controller state and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_soda         <= 1'b0;
      r_reject       <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= COIN_NONE;
      r_refund       <= 1'b0;
      r_credit       <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_soda   <= 1'b0;
      r_reject <= w_reject;
      case (r_state)
        IDLE, COLLECT: begin
          if (w_accept) begin
            r_credit <= w_sum;
            if (w_sum >= PRICE_C) begin
              r_state <= VEND;
              r_soda  <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= COLLECT;
            end
          end else if (i_cancel && (r_state == COLLECT)) begin
            r_state        <= DISPENSE;
            r_refund       <= 1'b1;
            r_busy         <= 1'b1;
            r_change_valid <= 1'b1;
            r_change_coin  <= pick_coin(r_credit);
          end else begin
            r_state <= r_state;
          end
        end
        VEND: begin
          r_credit <= w_after_vend;
          if (w_after_vend == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state        <= DISPENSE;
            r_refund       <= 1'b0;
            r_change_valid <= 1'b1;
            r_change_coin  <= pick_coin(w_after_vend);
          end
        end
        DISPENSE: begin
          // The presented coin is held until the hopper acknowledges it.
          if (i_change_ack) begin
            r_credit <= w_after_pay;
            if (w_after_pay == '0) begin
              r_state        <= IDLE;
              r_busy         <= 1'b0;
              r_change_valid <= 1'b0;
              r_change_coin  <= COIN_NONE;
              r_refund       <= 1'b0;
            end else begin
              r_change_coin <= pick_coin(w_after_pay);
            end
          end else begin
            r_state <= DISPENSE;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_credit       <= '0;
          r_change_valid <= 1'b0;
          r_change_coin  <= COIN_NONE;
          r_refund       <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign o_soda         = r_soda;
  assign o_coin_reject  = r_reject;
  assign o_change_valid = r_change_valid;
  assign o_change_coin  = r_change_coin;
  assign o_refunding    = r_refund;
  assign o_credit       = r_credit;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for vending_fsm_param: a dime-change and a nickel-only instance (both 20c)
// checked against directed tables, hand sequences and a coin-count reference model.
module tb_vending_fsm_param;

  logic clk;
  logic rst_n;
  logic i_nickel, i_dime, i_quarter, i_cancel, i_ack;

  logic       o0_soda, o0_rej, o0_valid, o0_refd, o0_busy;
  logic [1:0] o0_coin;
  logic [7:0] o0_credit;
  logic       o1_soda, o1_rej, o1_valid, o1_refd, o1_busy;
  logic [1:0] o1_coin;
  logic [7:0] o1_credit;

  int n_vec  = 0;
  int n_miss = 0;

  vending_fsm_param #(.PRICE(20), .CREDIT_W(8), .DIME_CHANGE(1'b1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_nickel(i_nickel), .i_dime(i_dime),
    .i_quarter(i_quarter), .i_cancel(i_cancel), .i_change_ack(i_ack),
    .o_soda(o0_soda), .o_coin_reject(o0_rej), .o_change_valid(o0_valid),
    .o_change_coin(o0_coin), .o_refunding(o0_refd), .o_credit(o0_credit), .o_busy(o0_busy)
  );

  vending_fsm_param #(.PRICE(20), .CREDIT_W(8), .DIME_CHANGE(1'b0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_nickel(i_nickel), .i_dime(i_dime),
    .i_quarter(i_quarter), .i_cancel(i_cancel), .i_change_ack(i_ack),
    .o_soda(o1_soda), .o_coin_reject(o1_rej), .o_change_valid(o1_valid),
    .o_change_coin(o1_coin), .o_refunding(o1_refd), .o_credit(o1_credit), .o_busy(o1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: credit while collecting, a vend flag, and the change still
  // owed kept as counts of dimes and nickels to be paid out (dimes first).
  localparam int PRICE = 20;
  int m_credit [2];
  bit m_vend   [2];
  int m_dimes  [2];
  int m_nick   [2];
  bit m_refund [2];
  bit m_reject [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_credit[k] = 0; m_vend[k] = 1'b0; m_dimes[k] = 0;
      m_nick[k] = 0; m_refund[k] = 1'b0; m_reject[k] = 1'b0;
    end
  endtask

  task automatic load_change(input int k, input int amount, input bit refund);
    if (k == 0) begin
      m_dimes[k] = amount / 10;
      m_nick[k]  = (amount % 10) / 5;
    end else begin
      m_dimes[k] = 0;
      m_nick[k]  = amount / 5;
    end
    m_refund[k] = refund && (amount > 0);
  endtask

  task automatic model_step(input int k, input bit n, input bit d, input bit q, input bit c, input bit a);
    int cnt;
    int pend;
    bit busy;
    cnt  = int'(n) + int'(d) + int'(q);
    pend = m_dimes[k] + m_nick[k];
    busy = m_vend[k] || (pend > 0);
    m_reject[k] = (cnt > 0) && ((cnt > 1) || c || busy);
    if (m_vend[k]) begin
      m_vend[k] = 1'b0;
      load_change(k, m_credit[k] - PRICE, 1'b0);
      m_credit[k] = 0;
    end else if (pend > 0) begin
      if (a) begin
        if (m_dimes[k] > 0) m_dimes[k]--;
        else m_nick[k]--;
        if (m_dimes[k] + m_nick[k] == 0) m_refund[k] = 1'b0;
      end
    end else if ((cnt == 1) && !c) begin
      m_credit[k] += n ? 5 : (d ? 10 : 25);
      if (m_credit[k] >= PRICE) m_vend[k] = 1'b1;
    end else if (c && (m_credit[k] > 0)) begin
      load_change(k, m_credit[k], 1'b1);
      m_credit[k] = 0;
    end
  endtask

  task automatic check_model(input int k, input logic soda, input logic rej, input logic valid,
                             input logic [1:0] coin, input logic refd, input logic [7:0] credit,
                             input logic busy);
    int pend;
    logic [1:0] e_coin;
    logic [7:0] e_credit;
    logic [14:0] e_v, g_v;
    pend     = m_dimes[k] + m_nick[k];
    e_coin   = (pend == 0) ? 2'b00 : ((m_dimes[k] > 0) ? 2'b10 : 2'b01);
    e_credit = 8'(m_credit[k] + 10 * m_dimes[k] + 5 * m_nick[k]);
    e_v = {m_vend[k], m_reject[k], (pend > 0), e_coin, m_refund[k], e_credit, (m_vend[k] || (pend > 0))};
    g_v = {soda, rej, valid, coin, refd, credit, busy};
    n_vec++;
    if (g_v !== e_v) begin
      n_miss++;
      $display("FAIL model dut%0d t=%0t got=%h exp=%h (soda,rej,valid,coin,ref,credit,busy)", k, $time, g_v, e_v);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // One clock: drive at negedge, step the model at the edge, compare at the next negedge.
  task automatic cycle(input bit n, input bit d, input bit q, input bit c, input bit a);
    i_nickel = n; i_dime = d; i_quarter = q; i_cancel = c; i_ack = a;
    @(posedge clk);
    model_step(0, n, d, q, c, a);
    model_step(1, n, d, q, c, a);
    @(negedge clk);
    check_model(0, o0_soda, o0_rej, o0_valid, o0_coin, o0_refd, o0_credit, o0_busy);
    check_model(1, o1_soda, o1_rej, o1_valid, o1_coin, o1_refd, o1_credit, o1_busy);
    i_nickel = 1'b0; i_dime = 1'b0; i_quarter = 1'b0; i_cancel = 1'b0; i_ack = 1'b0;
  endtask

  typedef struct {
    bit n, d, q, c, a;
    logic [14:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit n, input bit d, input bit q, input bit c, input bit a,
                              input bit soda, input bit rej, input bit valid, input logic [1:0] coin,
                              input bit refd, input int credit, input bit busy);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.c = c; v.a = a;
    v.exp = {soda, rej, valid, coin, refd, 8'(credit), busy};
    return v;
  endfunction

  vec_t tbl [23];

  initial begin
    logic [14:0] got;
    int exp_n [5];
    rst_n = 1'b0;
    i_nickel = 1'b0; i_dime = 1'b0; i_quarter = 1'b0; i_cancel = 1'b0; i_ack = 1'b0;
    model_reset();

    //           n  d  q  c  a   soda rej val coin    ref cr  busy
    tbl[0]  = mk(0, 0, 1, 0, 0,  1,   0,  0,  2'b00,  0,  25, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0,  0,   0,  1,  2'b01,  0,  5,  1);
    tbl[2]  = mk(0, 0, 0, 0, 1,  0,   0,  0,  2'b00,  0,  0,  0);
    tbl[3]  = mk(0, 1, 0, 0, 0,  0,   0,  0,  2'b00,  0,  10, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0,  1,   0,  0,  2'b00,  0,  20, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0,  0,   0,  0,  2'b00,  0,  0,  0);
    tbl[6]  = mk(1, 0, 0, 0, 0,  0,   0,  0,  2'b00,  0,  5,  0);
    tbl[7]  = mk(0, 1, 0, 0, 0,  0,   0,  0,  2'b00,  0,  15, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0,  1,   0,  0,  2'b00,  0,  40, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0,  0,   0,  1,  2'b10,  0,  20, 1);
    tbl[10] = mk(0, 0, 0, 0, 1,  0,   0,  1,  2'b10,  0,  10, 1);
    tbl[11] = mk(0, 0, 0, 0, 1,  0,   0,  0,  2'b00,  0,  0,  0);
    tbl[12] = mk(0, 1, 0, 0, 0,  0,   0,  0,  2'b00,  0,  10, 0);
    tbl[13] = mk(1, 0, 0, 0, 0,  0,   0,  0,  2'b00,  0,  15, 0);
    tbl[14] = mk(0, 0, 0, 1, 0,  0,   0,  1,  2'b10,  1,  15, 1);
    tbl[15] = mk(0, 0, 0, 0, 1,  0,   0,  1,  2'b01,  1,  5,  1);
    tbl[16] = mk(0, 0, 0, 0, 1,  0,   0,  0,  2'b00,  0,  0,  0);
    tbl[17] = mk(1, 1, 0, 0, 0,  0,   1,  0,  2'b00,  0,  0,  0);
    tbl[18] = mk(0, 0, 0, 0, 0,  0,   0,  0,  2'b00,  0,  0,  0);
    tbl[19] = mk(0, 0, 0, 1, 0,  0,   0,  0,  2'b00,  0,  0,  0);
    tbl[20] = mk(1, 0, 0, 0, 0,  0,   0,  0,  2'b00,  0,  5,  0);
    tbl[21] = mk(0, 1, 0, 1, 0,  0,   1,  1,  2'b01,  1,  5,  1);
    tbl[22] = mk(0, 0, 0, 0, 1,  0,   0,  0,  2'b00,  0,  0,  0);

    #12;
    chk("reset dut0 outputs", int'({o0_soda, o0_rej, o0_valid, o0_coin, o0_refd, o0_credit, o0_busy}), 0);
    chk("reset dut1 outputs", int'({o1_soda, o1_rej, o1_valid, o1_coin, o1_refd, o1_credit, o1_busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 40c with nickel-only change: four nickels, credit stepping down by 5.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("t3 vend credit", int'(o1_credit), 40);
    cycle(0, 0, 0, 0, 0);
    exp_n = '{20, 15, 10, 5, 0};
    for (int i = 0; i < 5; i++) begin
      chk("t3 nickel-only credit", int'(o1_credit), exp_n[i]);
      chk("t3 nickel-only coin", int'(o1_coin), (i < 4) ? 1 : 0);
      if (i < 4) cycle(0, 0, 0, 0, 1);
    end

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].c, tbl[i].a);
      got = {o0_soda, o0_rej, o0_valid, o0_coin, o0_refd, o0_credit, o0_busy};
      n_vec++;
      if (got !== tbl[i].exp) begin
        n_miss++;
        $display("FAIL tbl[%0d] got=%h exp=%h", i, got, tbl[i].exp);
      end
    end

    // Hopper stall with a quarter arriving mid-payout.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, (i == 2), 0, 0);
      chk("stall valid", int'(o0_valid), 1);
      chk("stall coin", int'(o0_coin), 2);
      chk("stall credit", int'(o0_credit), 10);
      chk("stall reject", int'(o0_rej), (i == 2) ? 1 : 0);
    end
    cycle(0, 0, 0, 0, 1);
    chk("stall end credit", int'(o0_credit), 0);
    chk("stall end busy", int'(o0_busy), 0);

    // Reset while 15c is still owed.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("pre-reset credit", int'(o0_credit), 15);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid reset dut0", int'({o0_soda, o0_rej, o0_valid, o0_coin, o0_refd, o0_credit, o0_busy}), 0);
    chk("mid reset dut1", int'({o1_soda, o1_rej, o1_valid, o1_coin, o1_refd, o1_credit, o1_busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 1);
    chk("post reset credit", int'(o0_credit), 0);
    chk("post reset busy", int'(o0_busy), 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      cycle((r == 1) || (r == 4) || (r == 6), (r == 2) || (r == 4), (r == 3) || (r == 6),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
